keyed_fifo_arbiter: RTL and testbench

- Parametrised successor of the ITC99 b03 arbiter family, carrying the structural time-varying key lock.
- Serves N_REQ requesters in first-come order through a grant queue QDEPTH entries deep.
- The lock works as follows: a free-running key-state counter selects one expected key word per cycle. A mismatch corrupts the SAMPLE/SERVE phase register.
- Intended as a lockable benchmark for the encrypted-benchmark suite, used by attack and verification flows.

---
 rtl/keyed_fifo_arbiter_pkg.sv | 24 ++
 rtl/key_schedule_checker.sv | 36 +++
 rtl/keyed_fifo_arbiter.sv | 123 ++++++++++++
 tb/tb_keyed_fifo_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/keyed_fifo_arbiter_pkg.sv
// Shared types and constants for the keyed FIFO arbiter and its key checker.
// Holds the phase encoding, the default key schedule and the one-hot grant helper.
package keyed_fifo_arbiter_pkg;

  typedef enum logic {
    SAMPLE = 1'b0,
    SERVE  = 1'b1
  } phase_e;

  localparam int MAX_REQ = 32;

  // Slice 0 (LSBs) is the key expected in key state 0.
  localparam logic [15:0] DEFAULT_KEY_SCHEDULE = {4'h9, 4'h6, 4'hA, 4'h3};

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n_req);
    logic [MAX_REQ-1:0] one;
    one = MAX_REQ'(1);
    if (idx < n_req) begin
      return one << idx;
    end
    return '0;
  endfunction

endpackage

// File: rtl/key_schedule_checker.sv
// Free-running key-state counter plus compare of keyinput against the scheduled slice.
// Combinational key_ok from the current state; the counter advances every cycle regardless.
module key_schedule_checker
  import keyed_fifo_arbiter_pkg::*;
#(
  parameter int KEY_BITS     = 4,
  parameter int N_KEY_STATES = 4,
  parameter logic [N_KEY_STATES*KEY_BITS-1:0] KEY_SCHEDULE = DEFAULT_KEY_SCHEDULE,
  localparam int KSW = $clog2(N_KEY_STATES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] keyinput,
  output logic                key_ok,
  output logic [KSW-1:0]      key_state
);

  logic [KSW-1:0] kcnt_q, kcnt_d;

  // N_KEY_STATES is a power of two, so natural overflow is the modulo wrap.
  always_comb begin
    kcnt_d = kcnt_q + 1'b1;
    key_ok = (keyinput == KEY_SCHEDULE[kcnt_q*KEY_BITS +: KEY_BITS]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kcnt_q <= '0;
    end else begin
      kcnt_q <= kcnt_d;
    end
  end

  assign key_state = kcnt_q;

endmodule

// File: rtl/keyed_fifo_arbiter.sv
// First-come arbiter with a grant queue; SAMPLE/SERVE phase toggles only on a correct key.
// Grant is registered: request sampled, queued on next SERVE, visible on the SAMPLE after.
module keyed_fifo_arbiter
  import keyed_fifo_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int QDEPTH       = 4,
  parameter int KEY_BITS     = 4,
  parameter int N_KEY_STATES = 4,
  parameter logic [N_KEY_STATES*KEY_BITS-1:0] KEY_SCHEDULE = DEFAULT_KEY_SCHEDULE,
  localparam int CW  = $clog2(QDEPTH+1),
  localparam int KSW = $clog2(N_KEY_STATES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    request,
  input  logic [KEY_BITS-1:0] keyinput,
  output logic [N_REQ-1:0]    grant_o,
  output logic [CW-1:0]       queue_count,
  output logic [KSW-1:0]      key_state
);

  localparam int IW = (N_REQ  > 1) ? $clog2(N_REQ)  : 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic key_ok;

  phase_e           phase_q, phase_d;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] grant_o_q, grant_o_d;
  logic [N_REQ-1:0] inq_q, inq_d;
  logic [IW-1:0]    mem_q [QDEPTH];
  logic [IW-1:0]    mem_d [QDEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MAX_REQ-1:0] head_oh;

  key_schedule_checker #(
    .KEY_BITS     (KEY_BITS),
    .N_KEY_STATES (N_KEY_STATES),
    .KEY_SCHEDULE (KEY_SCHEDULE)
  ) u_key_chk (
    .clock     (clock),
    .reset     (reset),
    .keyinput  (keyinput),
    .key_ok    (key_ok),
    .key_state (key_state)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    phase_d   = key_ok ? phase_e'(~phase_q) : phase_q;
    req_d     = req_q;
    grant_d   = grant_q;
    grant_o_d = grant_o_q;
    inq_d     = inq_q;
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    head_oh   = '0;

    if (phase_q == SAMPLE) begin
      req_d     = request;
      grant_o_d = grant_q;
    end else begin
      // Pop first so a released head frees its slot for this edge's pushes.
      if (cnt_q != '0 && !req_q[mem_q[head_q]]) begin
        inq_d[mem_q[head_q]] = 1'b0;
        head_d = ptr_inc(head_q);
        cnt_d  = cnt_q - 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_q[i] && !inq_d[i] && cnt_d < CW'(QDEPTH)) begin
          mem_d[tail_d] = IW'(i);
          inq_d[i]      = 1'b1;
          tail_d        = ptr_inc(tail_d);
          cnt_d         = cnt_d + 1'b1;
        end
      end
      if (cnt_d != '0) begin
        head_oh = onehot(32'(mem_d[head_d]), N_REQ);
        grant_d = head_oh[N_REQ-1:0];
      end else begin
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q   <= SAMPLE;
      req_q     <= '0;
      grant_q   <= '0;
      grant_o_q <= '0;
      inq_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      req_q     <= req_d;
      grant_q   <= grant_d;
      grant_o_q <= grant_o_d;
      inq_q     <= inq_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign grant_o     = grant_o_q;
  assign queue_count = cnt_q;

endmodule

// File: tb/tb_keyed_fifo_arbiter.sv
// Scoreboard bench: a shift-queue reference model predicts each edge for a depth-4 and a
// depth-2 arbiter sharing stimulus; predictions are queued on drive and compared after the edge.
module tb_keyed_fifo_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] request;
  logic [3:0] keyinput;
  logic [3:0] grant0, grant1;
  logic [2:0] count0;
  logic [1:0] count1;
  logic [1:0] kstate0, kstate1;

  keyed_fifo_arbiter #(.N_REQ(4), .QDEPTH(4)) dut0 (
    .clock(clock), .reset(reset), .request(request), .keyinput(keyinput),
    .grant_o(grant0), .queue_count(count0), .key_state(kstate0)
  );

  keyed_fifo_arbiter #(.N_REQ(4), .QDEPTH(2)) dut1 (
    .clock(clock), .reset(reset), .request(request), .keyinput(keyinput),
    .grant_o(grant1), .queue_count(count1), .key_state(kstate1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  typedef struct {
    logic [3:0] g0;
    int         c0;
    logic [3:0] g1;
    int         c1;
    int         ks;
  } exp_t;

  exp_t sb[$];

  int         sched [4] = '{3, 10, 6, 9};
  int         depth [2] = '{4, 2};
  bit         m_phase [2];
  logic [3:0] m_req   [2];
  logic [3:0] m_grant [2];
  logic [3:0] m_go    [2];
  int         mf      [2][4];
  int         mc      [2];
  int         m_k;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 1'b0;
      m_req[d]   = 4'h0;
      m_grant[d] = 4'h0;
      m_go[d]    = 4'h0;
      mc[d]      = 0;
    end
    m_k = 0;
  endtask

  task automatic model_edge(input logic [3:0] rq, input logic [3:0] key);
    bit ok;
    bit present;
    ok = (int'(key) == sched[m_k]);
    for (int d = 0; d < 2; d++) begin
      if (!m_phase[d]) begin
        m_req[d] = rq;
        m_go[d]  = m_grant[d];
      end else begin
        if (mc[d] > 0 && !m_req[d][mf[d][0]]) begin
          for (int j = 0; j < 3; j++) mf[d][j] = mf[d][j+1];
          mc[d]--;
        end
        for (int i = 0; i < 4; i++) begin
          if (m_req[d][i]) begin
            present = 1'b0;
            for (int j = 0; j < mc[d]; j++) if (mf[d][j] == i) present = 1'b1;
            if (!present && mc[d] < depth[d]) begin
              mf[d][mc[d]] = i;
              mc[d]++;
            end
          end
        end
        m_grant[d] = (mc[d] > 0) ? 4'(1 << mf[d][0]) : 4'h0;
      end
      if (ok) m_phase[d] = ~m_phase[d];
    end
    m_k = (m_k + 1) % 4;
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] key);
    exp_t e;
    request  = rq;
    keyinput = key;
    model_edge(rq, key);
    e.g0 = m_go[0]; e.c0 = mc[0]; e.g1 = m_go[1]; e.c1 = mc[1]; e.ks = m_k;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("grant0", 32'(grant0), 32'(e.g0));
    check("count0", 32'(count0), e.c0);
    check("grant1", 32'(grant1), 32'(e.g1));
    check("count1", 32'(count1), e.c1);
    check("kstate", 32'(kstate0), e.ks);
    check("no_x", 32'($isunknown({grant0, grant1, count0, count1})), 0);
  endtask

  task automatic step_ok(input logic [3:0] rq, input int n);
    for (int i = 0; i < n; i++) step(rq, 4'(sched[m_k]));
  endtask

  initial begin
    bit used;
    reset    = 1'b1;
    request  = 4'h0;
    keyinput = 4'h0;
    model_reset();
    #2;
    check("rst_grant", 32'(grant0), 0);
    check("rst_count", 32'(count0), 0);
    check("rst_kstate", 32'(kstate0), 0);
    reset = 1'b0;

    // Single requester: grant visible after the third edge.
    step_ok(4'b0001, 3);
    check("a_grant", 32'(grant0), 32'h1);
    check("a_count", 32'(count0), 1);
    step_ok(4'b0000, 4);
    check("a_release", 32'(grant0), 0);

    // Two simultaneous requesters queue in index order.
    step_ok(4'b0110, 4);
    check("b_grant", 32'(grant0), 32'h2);
    step_ok(4'b0100, 4);
    check("b_grant_next", 32'(grant0), 32'h4);
    check("b_count", 32'(count0), 1);

    // Depth-2 queue saturates; a pop makes room for a push on the same edge.
    step_ok(4'b0000, 4);
    step_ok(4'b1111, 4);
    check("c_count1", 32'(count1), 2);
    check("c_grant1", 32'(grant1), 32'h1);
    check("c_count0", 32'(count0), 4);
    step_ok(4'b1110, 4);
    check("c_grant1_next", 32'(grant1), 32'h2);
    check("c_count1_next", 32'(count1), 2);
    check("c_count0_next", 32'(count0), 3);

    // Constant wrong key freezes the phase.
    step_ok(4'b0000, 8);
    for (int i = 0; i < 12; i++) step(4'b1000, 4'h0);

    // Asynchronous reset mid-grant.
    step_ok(4'b0000, 8);
    step_ok(4'b0100, 4);
    check("e_pre_grant", 32'(grant0), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("e_rst_grant", 32'(grant0), 0);
    check("e_rst_count", 32'(count0), 0);
    check("e_rst_kstate", 32'(kstate0), 0);
    model_reset();
    #1;
    reset = 1'b0;
    step_ok(4'b0100, 3);
    check("e_resume", 32'(grant0), 32'h4);

    // One wrong key at key state 2 only delays the sequence.
    step_ok(4'b0000, 4);
    used = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!used && m_k == 2) begin
        step(4'b0011, 4'h7);
        used = 1'b1;
      end else begin
        step(4'b0011, 4'(sched[m_k]));
      end
    end
    check("f_grant", 32'(grant0), 32'h1);
    step_ok(4'b0010, 4);
    check("f_grant_next", 32'(grant0), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
